// File: rtl/fpu_issue_unit_if.sv
// Handshake and operand bus between decode/execute, the issue unit, the fpu and writeback.
// slave is the issue unit's view; master is the surrounding pipeline's view.
interface fpu_issue_unit_if;
   logic        start;
   logic        flush;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [31:0] data3;
   logic [4:0]  select;
   logic [4:0]  dest;
   logic [31:0] fpu_result;
   logic [31:0] fpu_data1;
   logic [31:0] fpu_data2;
   logic [31:0] fpu_data3;
   logic [4:0]  fpu_select;
   logic        busy;
   logic [31:0] result;
   logic [4:0]  result_dest;
   logic        result_valid;
   logic        illegal;

   modport slave (
      input  start, flush, data1, data2, data3, select, dest, fpu_result,
      output fpu_data1, fpu_data2, fpu_data3, fpu_select,
             busy, result, result_dest, result_valid, illegal
   );

   modport master (
      output start, flush, data1, data2, data3, select, dest, fpu_result,
      input  fpu_data1, fpu_data2, fpu_data3, fpu_select,
             busy, result, result_dest, result_valid, illegal
   );
endinterface

// File: rtl/fpu_issue_unit.sv
// Issue/sequencing stage for the combinational fpu: holds operands for an op-dependent
// number of cycles, then captures the result and pulses it to writeback with its tag.
module fpu_issue_unit #(
   parameter int unsigned LAT_SIMPLE = 1,
   parameter int unsigned LAT_ADDSUB = 2,
   parameter int unsigned LAT_MUL    = 3,
   parameter int unsigned LAT_DIV    = 8,
   parameter int unsigned LAT_FMA    = 4
) (
   input  logic             clk,
   input  logic             rst,
   fpu_issue_unit_if.slave  bus_io
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 5;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SEL_W-1:0]    tag_q, tag_d;
   logic                op_illegal_q, op_illegal_d;
   logic [DATA_W-1:0]   fpu_data1_q, fpu_data1_d;
   logic [DATA_W-1:0]   fpu_data2_q, fpu_data2_d;
   logic [DATA_W-1:0]   fpu_data3_q, fpu_data3_d;
   logic [SEL_W-1:0]    fpu_select_q, fpu_select_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic [SEL_W-1:0]    result_dest_q, result_dest_d;
   logic                result_valid_q, result_valid_d;
   logic                illegal_q, illegal_d;
   logic                busy_q, busy_d;
   logic                accept;

   // Settle time in cycles for each operation class
   function automatic logic [CNT_W-1:0] lat_of(input logic [SEL_W-1:0] sel);
      logic [CNT_W-1:0] lat;
      lat = CNT_W'(LAT_SIMPLE);
      if (sel inside {5'd1, 5'd2})            lat = CNT_W'(LAT_ADDSUB);
      else if (sel == 5'd3)                   lat = CNT_W'(LAT_MUL);
      else if (sel inside {5'd4, 5'd13})      lat = CNT_W'(LAT_DIV);
      else if (sel inside {[5'd14:5'd17]})    lat = CNT_W'(LAT_FMA);
      return lat;
   endfunction

   assign accept = (state_q != EXEC) && bus_io.start && !bus_io.flush;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      tag_d          = tag_q;
      op_illegal_d   = op_illegal_q;
      fpu_data1_d    = fpu_data1_q;
      fpu_data2_d    = fpu_data2_q;
      fpu_data3_d    = fpu_data3_q;
      fpu_select_d   = fpu_select_q;
      result_d       = result_q;
      result_dest_d  = result_dest_q;
      result_valid_d = 1'b0;
      illegal_d      = 1'b0;
      busy_d         = busy_q;

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               fpu_data1_d  = bus_io.data1;
               fpu_data2_d  = bus_io.data2;
               fpu_data3_d  = bus_io.data3;
               fpu_select_d = bus_io.select;
               tag_d        = bus_io.dest;
               op_illegal_d = (bus_io.select >= 5'd21);
               cnt_d        = lat_of(bus_io.select) - CNT_W'(1);
               state_d      = EXEC;
               busy_d       = 1'b1;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               result_d       = op_illegal_q ? '0 : bus_io.fpu_result;
               result_dest_d  = tag_q;
               result_valid_d = 1'b1;
               illegal_d      = op_illegal_q;
               state_d        = DONE;
               busy_d         = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Abort overrides everything, including a same-cycle start; data registers keep their values
      if (bus_io.flush) begin
         state_d        = IDLE;
         result_valid_d = 1'b0;
         illegal_d      = 1'b0;
         busy_d         = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         tag_q          <= '0;
         op_illegal_q   <= 1'b0;
         fpu_data1_q    <= '0;
         fpu_data2_q    <= '0;
         fpu_data3_q    <= '0;
         fpu_select_q   <= '0;
         result_q       <= '0;
         result_dest_q  <= '0;
         result_valid_q <= 1'b0;
         illegal_q      <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         tag_q          <= tag_d;
         op_illegal_q   <= op_illegal_d;
         fpu_data1_q    <= fpu_data1_d;
         fpu_data2_q    <= fpu_data2_d;
         fpu_data3_q    <= fpu_data3_d;
         fpu_select_q   <= fpu_select_d;
         result_q       <= result_d;
         result_dest_q  <= result_dest_d;
         result_valid_q <= result_valid_d;
         illegal_q      <= illegal_d;
         busy_q         <= busy_d;
      end
   end

   assign bus_io.fpu_data1    = fpu_data1_q;
   assign bus_io.fpu_data2    = fpu_data2_q;
   assign bus_io.fpu_data3    = fpu_data3_q;
   assign bus_io.fpu_select   = fpu_select_q;
   assign bus_io.busy         = busy_q;
   assign bus_io.result       = result_q;
   assign bus_io.result_dest  = result_dest_q;
   assign bus_io.result_valid = result_valid_q;
   assign bus_io.illegal      = illegal_q;

endmodule

// File: tb/tb_fpu_issue_unit.sv
// Scoreboard bench for fpu_issue_unit: expected results are queued at issue and
// compared (value, tag, illegal flag, arrival edge) whenever RESULT_VALID pulses.
module tb_fpu_issue_unit;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_errors;

   fpu_issue_unit_if bus ();

   fpu_issue_unit dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus.slave)
   );

   typedef struct {
      logic [31:0] res;
      logic [4:0]  dest;
      logic        ill;
      int          due;
   } exp_t;

   exp_t sb_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the combinational fpu
   function automatic logic [31:0] fpu_model(input logic [4:0] sel, input logic [31:0] d1,
                                             input logic [31:0] d2, input logic [31:0] d3);
      if (sel == 5'd3 && d1 == 32'h4000_0000 && d2 == 32'h4040_0000) return 32'h40C0_0000;
      return d1 ^ {d2[23:0], d2[31:24]} ^ ~d3 ^ {27'd0, sel};
   endfunction

   function automatic int lat_model(input logic [4:0] sel);
      int s;
      s = int'(sel);
      if (s == 1 || s == 2) return 2;
      if (s == 3) return 3;
      if (s == 4 || s == 13) return 8;
      if (s >= 14 && s <= 17) return 4;
      return 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Result monitor: every RESULT_VALID must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && bus.result_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("result", bus.result, e.res);
            check("result_dest", 32'(bus.result_dest), 32'(e.dest));
            check("illegal", 32'(bus.illegal), 32'(e.ill));
            check("latency_edge", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic issue(input logic [4:0] sel, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] d3, input logic [4:0] dst, input bit expect_res,
                        output int k);
      exp_t e;
      @(negedge clk);
      bus.select = sel; bus.data1 = d1; bus.data2 = d2; bus.data3 = d3; bus.dest = dst;
      bus.start  = 1'b1;
      k = cyc + 1;
      if (expect_res) begin
         e.ill  = (sel >= 5'd21);
         e.res  = e.ill ? 32'd0 : fpu_model(sel, d1, d2, d3);
         e.dest = dst;
         e.due  = k + lat_model(sel);
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_edge(input int n);
      do begin
         @(posedge clk);
         #1;
      end while (cyc < n);
   endtask

   task automatic wait_drain(input int max_cycles);
      for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         check("drain_timeout", 32'(sb_q.size()), 32'd0);
         sb_q.delete();
      end
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_busy"}, 32'(bus.busy), 32'd0);
      check({pfx, "_valid"}, 32'(bus.result_valid), 32'd0);
      check({pfx, "_illegal"}, 32'(bus.illegal), 32'd0);
      check({pfx, "_result"}, bus.result, 32'd0);
      check({pfx, "_dest"}, 32'(bus.result_dest), 32'd0);
      check({pfx, "_fpu_d1"}, bus.fpu_data1, 32'd0);
      check({pfx, "_fpu_d3"}, bus.fpu_data3, 32'd0);
      check({pfx, "_fpu_sel"}, 32'(bus.fpu_select), 32'd0);
   endtask

   assign bus.fpu_result = fpu_model(bus.fpu_select, bus.fpu_data1, bus.fpu_data2, bus.fpu_data3);

   initial begin
      int k;
      logic [31:0] x1;
      logic [31:0] prev_res;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      bus.start = 1'b0; bus.flush = 1'b0;
      bus.data1 = '0; bus.data2 = '0; bus.data3 = '0; bus.select = '0; bus.dest = '0;
      #1 rst = 1'b1;
      #1 check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // FMUL: 3-cycle busy window, result 3 edges after accept
      issue(5'd3, 32'h4000_0000, 32'h4040_0000, 32'd0, 5'd5, 1'b1, k);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("fmul_busy%0d", i), 32'(bus.busy), (i < 3) ? 32'd1 : 32'd0);
      end
      wait_drain(20);

      // FDIV with START held: ignored in EXEC, second op accepted on the valid cycle
      @(negedge clk);
      bus.select = 5'd4; bus.data1 = 32'h1111_2222; bus.data2 = 32'h3333_4444;
      bus.data3 = 32'h5555_6666; bus.dest = 5'd7; bus.start = 1'b1;
      k = cyc + 1;
      sb_q.push_back('{fpu_model(5'd4, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666), 5'd7, 1'b0, k + 8});
      x1 = 32'hABCD_0123;
      @(posedge clk);
      #1 bus.data1 = x1; bus.dest = 5'd8;
      sb_q.push_back('{fpu_model(5'd4, x1, 32'h3333_4444, 32'h5555_6666), 5'd8, 1'b0, k + 17});
      prev_res = fpu_model(5'd4, x1, 32'h3333_4444, 32'h5555_6666);
      wait_edge(k + 3);
      check("hold_fpu_d1", bus.fpu_data1, 32'h1111_2222);
      check("hold_busy", 32'(bus.busy), 32'd1);
      wait_edge(k + 9);
      bus.start = 1'b0;
      check("b2b_fpu_d1", bus.fpu_data1, x1);
      check("b2b_busy", 32'(bus.busy), 32'd1);
      wait_drain(30);

      // FLUSH on the 4th EXEC cycle, then FLUSH together with START
      issue(5'd4, 32'h0F0F_0F0F, 32'h7777_0000, 32'h0000_8888, 5'd12, 1'b0, k);
      wait_edge(k + 3);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      check("flush_busy", 32'(bus.busy), 32'd0);
      check("flush_result_kept", bus.result, prev_res);
      check("flush_dest_kept", 32'(bus.result_dest), 32'd8);
      check("flush_fpu_d1_kept", bus.fpu_data1, 32'h0F0F_0F0F);
      @(negedge clk);
      bus.select = 5'd3; bus.data1 = 32'hDEAD_BEEF; bus.start = 1'b1;
      @(posedge clk);
      #1;
      check("flush_start_busy", 32'(bus.busy), 32'd0);
      check("flush_start_sel", 32'(bus.fpu_select), 32'd4);
      bus.flush = 1'b0; bus.start = 1'b0;
      repeat (12) @(negedge clk);
      check("post_flush_busy", 32'(bus.busy), 32'd0);

      // Illegal op: result forced to zero, flagged, 1-cycle latency
      issue(5'd22, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1357_9BDF, 5'd9, 1'b1, k);
      wait_drain(10);

      // Async reset mid-FMA aborts it; a following FSGNJ completes normally
      issue(5'd14, 32'h2468_ACE0, 32'h1111_1111, 32'h2222_2222, 5'd3, 1'b0, k);
      wait_edge(k + 2);
      #2 rst = 1'b1;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      issue(5'd7, 32'h8000_0001, 32'h0000_0002, 32'h0000_0003, 5'd17, 1'b1, k);
      @(negedge clk);
      check("fsgnj_busy0", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check("fsgnj_busy1", 32'(bus.busy), 32'd0);
      wait_drain(10);

      // Every opcode once, exercising the full latency table
      for (int s = 0; s < 32; s++) begin
         issue(5'(s), $urandom, $urandom, $urandom, 5'(31 - s), 1'b1, k);
         wait_drain(20);
      end

      repeat (4) @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fpu_issue_unit.md
# fpu_issue_unit

Multi-cycle issue and sequencing stage that sits directly upstream of the combinational `fpu` block in the CPU's floating-point path. It accepts one FP operation at a time from the decode/execute side and latches the operands and the 5-bit operation select into registers that drive the `fpu` inputs. It holds those inputs stable for an operation-dependent number of cycles so the long combinational paths (divide, fused multiply-add) settle. It then captures the `fpu` result and presents it with a destination tag and a one-cycle valid pulse to writeback.

## Interface
Parameters:
- LAT_SIMPLE, 1, cycles for forward, min/max, sign-inject, compare, convert and class ops
- LAT_ADDSUB, 2, cycles for FADD/FSUB
- LAT_MUL, 3, cycles for FMUL
- LAT_DIV, 8, cycles for FDIV and FSQRT
- LAT_FMA, 4, cycles for FMADD/FMSUB/FNMADD/FNMSUB
- All latencies are legal in the range 1..15; the counter is 4 bits.

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high; clears all state immediately
- START  in  1  request to issue an operation; sampled only when the unit accepts (see Operation)
- FLUSH  in  1  synchronous abort of the in-flight operation
- DATA1, DATA2, DATA3  in  32 each  operands
- SELECT  in  5  operation code, same encoding as the `fpu` SELECT
- DEST  in  5  destination FP register tag
- FPU_RESULT  in  32  combinational result returned by `fpu`
- FPU_DATA1, FPU_DATA2, FPU_DATA3  out  32 each  registered operands driving `fpu`
- FPU_SELECT  out  5  registered select driving `fpu`
- BUSY  out  1  high while an operation is executing; the upstream stage stalls on it
- RESULT  out  32  captured result
- RESULT_DEST  out  5  tag of RESULT
- RESULT_VALID  out  1  one-cycle pulse marking a new RESULT
- ILLEGAL  out  1  high together with RESULT_VALID when SELECT was 10101..11111

## Operation
- States: IDLE, EXEC, DONE. Reset puts the unit in IDLE.
- Accept condition: state is IDLE or DONE, START=1 and FLUSH=0.
  - In DONE, the unit accepts back-to-back in the same cycle as RESULT_VALID.
  - START is ignored in EXEC.
- On accept:
  - Latch DATA1..3 into FPU_DATA1..3, SELECT into FPU_SELECT, and DEST into an internal tag.
  - Load CNT = L-1 and go to EXEC.
- Latency L by SELECT:
  - 00000 and 00101..01100: LAT_SIMPLE
  - 00001, 00010: LAT_ADDSUB
  - 00011: LAT_MUL
  - 00100, 01101: LAT_DIV
  - 01110..10001: LAT_FMA
  - 10010..10100: LAT_SIMPLE
  - 10101..11111: LAT_SIMPLE, marked illegal
- EXEC, CNT≠0: decrement CNT.
- EXEC, CNT=0:
  - Capture FPU_RESULT into RESULT, or 32'd0 if illegal.
  - Copy the tag to RESULT_DEST.
  - Set RESULT_VALID=1 and ILLEGAL as applicable.
  - Go to DONE.
- DONE: RESULT_VALID and ILLEGAL clear on the next edge. Next state is EXEC on accept, otherwise IDLE.
- BUSY=1 exactly while state is EXEC (registered).
- FLUSH=1 at an edge, from any state:
  - Next state is IDLE, and RESULT_VALID, ILLEGAL and BUSY go to 0.
  - RESULT, RESULT_DEST and the FPU_* registers keep their values.
  - FLUSH and START in the same cycle: FLUSH wins and the START is dropped.
- RESULT, RESULT_DEST and the FPU_* outputs hold their last values between operations.

## Timing
- Reset values (asynchronous, immediate): every output is 0, CNT=0, state IDLE.
- Latency: START accepted at edge k gives RESULT_VALID=1 during the cycle after edge k+L, deasserted after edge k+L+1.
- Throughput: one operation per L+1... no: an operation issued on its predecessor's RESULT_VALID cycle gives one result every L+1 edges, with no bubble beyond the DONE cycle.
- BUSY rises after edge k and falls after edge k+L.
- FPU_* inputs are stable from edge k through edge k+L inclusive, giving L full cycles of settle time for `fpu`.
- RESET asserted mid-EXEC aborts the operation; no RESULT_VALID is ever produced for it.

## Test plan
- Reset, then START with SELECT=00011 (FMUL), DATA1=0x40000000, DATA2=0x40400000, DEST=5, with the `fpu` model returning 0x40C00000:
  - BUSY is high for 3 cycles.
  - RESULT_VALID pulses once, 3 cycles after the accept edge, with RESULT=0x40C00000 and RESULT_DEST=5.
- FDIV (SELECT=00100) followed by START held high throughout:
  - START is ignored during EXEC.
  - The second op is accepted on the RESULT_VALID cycle.
  - Results arrive 9 edges apart.
- FLUSH at the 4th EXEC cycle of an FDIV:
  - No RESULT_VALID is produced and BUSY drops after that edge.
  - RESULT keeps its previous value.
  - FLUSH asserted together with a new START: no accept, and the unit stays IDLE.
- SELECT=10110 (illegal), DEST=9: after 1 cycle, RESULT_VALID=1, ILLEGAL=1, RESULT=0, RESULT_DEST=9.
- Assert RESET asynchronously mid-FMA (SELECT=01110):
  - All outputs read 0 immediately.
  - No stray RESULT_VALID after RESET is released.
  - A following FSGNJ (SELECT=00111) completes in 1 cycle.
